// File: rtl/alu_pkg.sv
// alu_pkg: shared definitions for the ALU result path.
//   - op-select encodings of the five result sources
//   - default result / op-tag widths
//   - queue entry packing order, MSB first: {result, op, ovf, zero[, par]}
// Optional macro ALU_RESULT_FIFO_PARITY_EN appends a parity bit to each entry.
package alu_pkg;

  localparam int unsigned ALU_WIDTH = 4;
  localparam int unsigned ALU_OPW   = 3;

  typedef enum logic [2:0] {
    OP_ADD = 3'b000,
    OP_SUB = 3'b001,
    OP_AND = 3'b010,
    OP_OR  = 3'b011,
    OP_SLT = 3'b100
  } alu_op_e;

  // Width of one packed queue entry: result + op + ovf + zero (+ par).
  function automatic int unsigned entry_w(input int unsigned w, input int unsigned opw);
`ifdef ALU_RESULT_FIFO_PARITY_EN
    return w + opw + 3;
`else
    return w + opw + 2;
`endif
  endfunction

endpackage

// File: rtl/fifo_ptr_ctrl.sv
// fifo_ptr_ctrl: read/write pointers, occupancy count and handshake
// qualification for a power-of-two-depth FIFO.
//   push_req / pop_req : raw in_valid / out_ready from the datapath
//   push               : qualified write strobe (push_req && in_ready)
//   in_ready           : not full, and low until the first edge after reset
//   out_valid          : count != 0
//   wr_ptr / rd_ptr    : storage indices, wrap modulo DEPTH
//   count              : occupied entries, 0..DEPTH
module fifo_ptr_ctrl #(
  parameter  int unsigned DEPTH = 4,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          push_req,
  input  logic          pop_req,
  output logic          push,
  output logic          in_ready,
  output logic          out_valid,
  output logic [AW-1:0] wr_ptr,
  output logic [AW-1:0] rd_ptr,
  output logic [CW-1:0] count
);

  logic [AW-1:0] wr_ptr_q, wr_ptr_d;
  logic [AW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          live_q, live_d;
  logic          pop;

  always_comb begin
    // in_ready comes from registered state only; live_q holds it low
    // through reset and until the first edge after release.
    in_ready  = live_q && (count_q != CW'(DEPTH));
    out_valid = (count_q != '0);
    push      = push_req && in_ready;
    pop       = pop_req && out_valid;
    live_d    = 1'b1;
    wr_ptr_d  = push ? wr_ptr_q + AW'(1) : wr_ptr_q;
    rd_ptr_d  = pop  ? rd_ptr_q + AW'(1) : rd_ptr_q;
    count_d   = count_q;
    if (push && !pop) count_d = count_q + CW'(1);
    if (pop && !push) count_d = count_q - CW'(1);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      live_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      live_q   <= live_d;
    end
  end

  assign wr_ptr = wr_ptr_q;
  assign rd_ptr = rd_ptr_q;
  assign count  = count_q;

endmodule

// File: rtl/alu_result_fifo.sv
// alu_result_fifo: first-word-fall-through buffer behind the ALU output
// selector. Each entry holds {result, op, ovf, zero}; zero is computed on
// write. A sticky overflow bit records any accepted entry with ovf set.
//   in_valid/in_ready/in_result/in_op/in_ovf : upstream push side
//   out_valid/out_ready/out_result/out_op/out_ovf/out_zero : head entry,
//     all-zero while out_valid is low
//   count      : occupied entries
//   sticky_ovf : set by accepted ovf entries, cleared by sticky_clr (set wins)
// Optional macro ALU_RESULT_FIFO_PARITY_EN adds per-entry even parity,
// output out_par_err and parity-injection input inj_par.
module alu_result_fifo
  import alu_pkg::*;
#(
  parameter  int unsigned WIDTH = ALU_WIDTH,
  parameter  int unsigned DEPTH = 4,
  parameter  int unsigned OPW   = ALU_OPW,
  localparam int unsigned AW    = $clog2(DEPTH),
  localparam int unsigned CW    = AW + 1
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] in_result,
  input  logic [OPW-1:0]   in_op,
  input  logic             in_ovf,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] out_result,
  output logic [OPW-1:0]   out_op,
  output logic             out_ovf,
  output logic             out_zero,
`ifdef ALU_RESULT_FIFO_PARITY_EN
  output logic             out_par_err,
  input  logic             inj_par,
`endif
  output logic [CW-1:0]    count,
  output logic             sticky_ovf,
  input  logic             sticky_clr
);

  localparam int unsigned EW = entry_w(WIDTH, OPW);

  logic          push;
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [EW-1:0] mem_q [DEPTH];
  logic [EW-1:0] mem_d [DEPTH];
  logic [EW-1:0] wr_entry;
  logic [EW-1:0] head;
  logic          sticky_q, sticky_d;

  fifo_ptr_ctrl #(.DEPTH(DEPTH)) u_ptr (
    .clk       (clk),
    .rst       (rst),
    .push_req  (in_valid),
    .pop_req   (out_ready),
    .push      (push),
    .in_ready  (in_ready),
    .out_valid (out_valid),
    .wr_ptr    (wr_ptr),
    .rd_ptr    (rd_ptr),
    .count     (count)
  );

  always_comb begin
`ifdef ALU_RESULT_FIFO_PARITY_EN
    wr_entry = {in_result, in_op, in_ovf, (in_result == '0),
                (^{in_result, in_op, in_ovf}) ^ inj_par};
`else
    wr_entry = {in_result, in_op, in_ovf, (in_result == '0)};
`endif
    mem_d = mem_q;
    if (push) mem_d[wr_ptr] = wr_entry;
  end

  // Storage needs no reset: count gates every read of it.
  always_ff @(posedge clk) begin
    mem_q <= mem_d;
  end

  always_comb begin
    head = out_valid ? mem_q[rd_ptr] : '0;
  end

`ifdef ALU_RESULT_FIFO_PARITY_EN
  logic head_par;
  assign {out_result, out_op, out_ovf, out_zero, head_par} = head;
  assign out_par_err = out_valid && ((^{out_result, out_op, out_ovf}) != head_par);
`else
  assign {out_result, out_op, out_ovf, out_zero} = head;
`endif

  always_comb begin
    sticky_d = sticky_q;
    if (sticky_clr)       sticky_d = 1'b0;
    if (push && in_ovf)   sticky_d = 1'b1;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) sticky_q <= 1'b0;
    else     sticky_q <= sticky_d;
  end

  assign sticky_ovf = sticky_q;

endmodule

// File: tb/tb_alu_result_fifo.sv
module tb_alu_result_fifo;
  import alu_pkg::*;

  localparam int W = 4;
  localparam int D = 4;
  localparam int O = 3;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_result = '0;
  logic [O-1:0] in_op = '0;
  logic         in_ovf = 1'b0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_result;
  logic [O-1:0] out_op;
  logic         out_ovf;
  logic         out_zero;
  logic [2:0]   count;
  logic         sticky_ovf;
  logic         sticky_clr = 1'b0;
`ifdef ALU_RESULT_FIFO_PARITY_EN
  logic         out_par_err;
  logic         inj_par = 1'b0;
`endif

  always #5 clk = ~clk;

  alu_result_fifo #(.WIDTH(W), .DEPTH(D), .OPW(O)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_result  (in_result),
    .in_op      (in_op),
    .in_ovf     (in_ovf),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .out_result (out_result),
    .out_op     (out_op),
    .out_ovf    (out_ovf),
    .out_zero   (out_zero),
`ifdef ALU_RESULT_FIFO_PARITY_EN
    .out_par_err(out_par_err),
    .inj_par    (inj_par),
`endif
    .count      (count),
    .sticky_ovf (sticky_ovf),
    .sticky_clr (sticky_clr)
  );

  typedef struct packed {
    logic [3:0] res;
    logic [2:0] op;
    logic       ovf;
    logic       zero;
    logic       perr;
  } exp_t;

  exp_t sb[$];
  int   total = 0;
  int   bad = 0;
  int   mcnt = 0;
  bit   mup = 1'b0;
  bit   msticky = 1'b0;

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  // One clock of stimulus, entered and left 1 time unit after a rising edge.
  task automatic step(input bit v, input bit r, input logic [3:0] d, input logic [2:0] op,
                      input bit ovf, input bit clr, input bit inj);
    bit push, pop;
    in_valid = v; out_ready = r; in_result = d; in_op = op; in_ovf = ovf; sticky_clr = clr;
`ifdef ALU_RESULT_FIFO_PARITY_EN
    inj_par = inj;
`endif
    push = v && mup && (mcnt != D);
    pop  = r && (mcnt != 0);
    if (push) sb.push_back('{res: d, op: op, ovf: ovf, zero: (d == 4'h0), perr: inj});
    @(posedge clk);
    mcnt = mcnt + int'(push) - int'(pop);
    if (push && ovf) msticky = 1'b1;
    else if (clr)    msticky = 1'b0;
    mup = 1'b1;
    #1;
    in_valid = 1'b0; out_ready = 1'b0; sticky_clr = 1'b0;
`ifdef ALU_RESULT_FIFO_PARITY_EN
    inj_par = 1'b0;
`endif
  endtask

  // Monitor: on each falling edge compare state against the model and,
  // when a pop will occur on the next rising edge, check the head entry.
  always @(negedge clk) begin
    if (!rst) begin
      check("out_valid", int'(out_valid), int'(mcnt != 0));
      check("count", int'(count), mcnt);
      check("in_ready", int'(in_ready), int'(mup && mcnt != D));
      check("sticky_ovf", int'(sticky_ovf), int'(msticky));
      if (!out_valid) begin
        check("idle_outputs_zero", int'({out_result, out_op, out_ovf, out_zero}), 0);
      end else if (out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_pop", 1, 0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("out_result", int'(out_result), int'(e.res));
          check("out_op", int'(out_op), int'(e.op));
          check("out_ovf", int'(out_ovf), int'(e.ovf));
          check("out_zero", int'(out_zero), int'(e.zero));
`ifdef ALU_RESULT_FIFO_PARITY_EN
          check("out_par_err", int'(out_par_err), int'(e.perr));
`endif
        end
      end
    end
  end

  initial begin
    // Reset state
    #1;
    check("rst_count", int'(count), 0);
    check("rst_out_valid", int'(out_valid), 0);
    check("rst_outputs", int'({out_result, out_op, out_ovf, out_zero}), 0);
    check("rst_in_ready", int'(in_ready), 0);
    check("rst_sticky", int'(sticky_ovf), 0);
    #11 rst = 1'b0;            // t=12, between edges
    #1 check("in_ready_before_edge", int'(in_ready), 0);
    @(posedge clk); mup = 1'b1; #1;
    check("in_ready_after_edge", int'(in_ready), 1);

    // Single pass
    step(1, 0, 4'hA, 3'b001, 0, 0, 0);
    check("sp_valid", int'(out_valid), 1);
    check("sp_result", int'(out_result), 'hA);
    check("sp_op", int'(out_op), 1);
    check("sp_zero", int'(out_zero), 0);
    step(0, 1, 4'h0, 3'b000, 0, 0, 0);
    check("sp_valid_after_pop", int'(out_valid), 0);

    // Fill, ignored fifth push, drain in order, pop on empty ignored
    for (int i = 1; i <= 4; i++) step(1, 0, 4'(i), OP_AND, 0, 0, 0);
    check("full_count", int'(count), 4);
    check("full_in_ready", int'(in_ready), 0);
    step(1, 0, 4'h5, OP_OR, 0, 0, 0);
    check("full_ignored_count", int'(count), 4);
    check("full_head", int'(out_result), 1);
    step(0, 1, 4'h5, OP_OR, 0, 0, 0);
    check("full_pop_count", int'(count), 3);
    for (int i = 0; i < 3; i++) step(0, 1, 4'h0, OP_ADD, 0, 0, 0);
    check("drained_count", int'(count), 0);
    step(0, 1, 4'h0, OP_ADD, 0, 0, 0);
    check("empty_pop_count", int'(count), 0);

    // Simultaneous push/pop across pointer wrap
    step(1, 0, 4'h0 + 4'd6, OP_SUB, 0, 0, 0);
    step(1, 0, 4'd7, OP_SUB, 0, 0, 0);
    for (int i = 0; i < 10; i++) begin
      step(1, 1, 4'(8 + i), OP_SLT, 0, 0, 0);
      check("wrap_count", int'(count), 2);
    end
    step(0, 1, 4'h0, OP_ADD, 0, 0, 0);
    step(0, 1, 4'h0, OP_ADD, 0, 0, 0);

    // Flags: zero/ovf, set beats clear, clear alone
    step(1, 0, 4'h0, OP_ADD, 1, 0, 0);
    check("flag_zero", int'(out_zero), 1);
    check("flag_ovf", int'(out_ovf), 1);
    check("flag_sticky", int'(sticky_ovf), 1);
    step(1, 1, 4'h3, OP_SUB, 1, 1, 0);
    check("sticky_set_wins", int'(sticky_ovf), 1);
    step(0, 1, 4'h0, OP_ADD, 0, 1, 0);
    check("sticky_cleared", int'(sticky_ovf), 0);

`ifdef ALU_RESULT_FIFO_PARITY_EN
    step(1, 0, 4'h7, OP_OR, 0, 0, 1);
    check("par_err_injected", int'(out_par_err), 1);
    step(0, 1, 4'h0, OP_ADD, 0, 0, 0);
    step(1, 0, 4'h7, OP_OR, 0, 0, 0);
    check("par_err_clean", int'(out_par_err), 0);
    step(0, 1, 4'h0, OP_ADD, 0, 0, 0);
`endif

    // Asynchronous reset mid-operation with three entries held
    step(1, 0, 4'h9, OP_ADD, 1, 0, 0);
    step(1, 0, 4'hB, OP_SUB, 0, 0, 0);
    step(1, 0, 4'hC, OP_AND, 0, 0, 0);
    check("pre_reset_count", int'(count), 3);
    #2 rst = 1'b1;
    sb.delete(); mcnt = 0; mup = 1'b0; msticky = 1'b0;
    #1;
    check("mid_rst_count", int'(count), 0);
    check("mid_rst_valid", int'(out_valid), 0);
    check("mid_rst_sticky", int'(sticky_ovf), 0);
    check("mid_rst_in_ready", int'(in_ready), 0);
    @(negedge clk); #2 rst = 1'b0;
    @(posedge clk); mup = 1'b1; #1;
    check("post_rst_in_ready", int'(in_ready), 1);
    step(1, 1, 4'hE, OP_SLT, 0, 0, 0);
    step(0, 1, 4'h0, OP_ADD, 0, 0, 0);
    step(0, 0, 4'h0, OP_ADD, 0, 0, 0);
    check("scoreboard_empty", sb.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/alu_result_fifo.md
Name: alu_result_fifo

Overview:
- Registered buffering stage directly downstream of the ALU output selector.
- Captures each selected 4-bit result together with its 3-bit op select and overflow flag. Holds them in a small first-word-fall-through queue and presents them to the consumer under valid/ready.
- Computes a per-entry zero flag and a sticky overflow status for the control/debug path.

Parameters:
- WIDTH, 4: result width; matches the selector's result bus.
- DEPTH, 4: number of queue entries; power of two, minimum 2.
- OPW, 3: width of the op-select tag (s2..s0).

Ports:
- clk  input  1  single clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- in_valid  input  1  upstream result is valid this cycle.
- in_ready  output  1  queue can accept; equals not-full.
- in_result  input  WIDTH  selected ALU result.
- in_op  input  OPW  op select {s2,s1,s0} that produced in_result.
- in_ovf  input  1  overflow flag for in_result.
- out_valid  output  1  head entry valid.
- out_ready  input  1  consumer accepts head entry.
- out_result  output  WIDTH  head result.
- out_op  output  OPW  head op tag.
- out_ovf  output  1  head overflow flag.
- out_zero  output  1  head result == 0.
- count  output  clog2(DEPTH)+1  occupied entries, 0..DEPTH.
- sticky_ovf  output  1  set by any accepted entry with ovf=1.
- sticky_clr  input  1  clears sticky_ovf.

Behaviour:
- Clock and reset: one clock; reset is asynchronous and active-high.
- Reset state:
  - count=0, read/write pointers=0, out_valid=0, sticky_ovf=0.
  - out_result, out_op, out_ovf and out_zero all read 0.
  - in_ready=0 while rst is high, then 1 from the first clk edge after release.
- Push: accepted on a clk edge when in_valid and in_ready.
  - Stores {in_result, in_op, in_ovf, zero}, where zero = (in_result == 0). zero is computed at write time.
- Pop: occurs on a clk edge when out_valid and out_ready.
- Latency: an entry pushed into an empty queue at edge N shows out_valid=1 after edge N. It is poppable at edge N+1.
- out_* reflect the head entry (FWFT). When out_valid=0 they read 0.
- in_ready = (count != DEPTH). It depends only on registered state, never on out_ready (no combinational ready path).
- Full + pop request: in_ready is already 0, so only the pop occurs; count becomes DEPTH-1.
- Empty + push: no pop is possible the same cycle; count becomes 1.
- Push and pop in the same cycle (0 < count < DEPTH): count is unchanged and both pointers advance.
- Pointers wrap modulo DEPTH. count is tracked separately, so full and empty are unambiguous.
- Ignored requests:
  - in_valid while full: ignored, with no state change. Upstream must hold its data.
  - out_ready while empty: ignored.
- sticky_ovf:
  - Set on an edge that accepts an entry with in_ovf=1.
  - Cleared on an edge with sticky_clr=1.
  - If set and clear occur on the same edge, set wins.
- Reset mid-operation: all contents are discarded immediately (asynchronous). No partial pop or push completes.

Optional Feature:
- Macro: ALU_RESULT_FIFO_PARITY_EN.
- When defined:
  - Each entry additionally stores even parity over {in_result, in_op, in_ovf}, computed at push.
  - Extra output port out_par_err (1 bit) is high when the head entry's recomputed parity mismatches the stored bit and out_valid=1.
  - Extra input port inj_par (1 bit) inverts the stored parity bit of the entry pushed that cycle, for test.
- When undefined: neither port exists, no parity storage is instantiated, and behaviour is otherwise identical.

Decomposition:
- Shared package alu_pkg holds:
  - op-select encodings for the five result sources (ADD, SUB, AND, OR, SLT: 3'b000..3'b100);
  - the default WIDTH and OPW;
  - the entry-field packing order {result, op, ovf, zero[, par]}.
- One natural sub-module, fifo_ptr_ctrl: pointers, count, full/empty and in_ready generation.
- The storage array and flag logic stay in alu_result_fifo.

Test Plan:
- Reset then idle: assert rst mid-run with count=3 -> count=0, out_valid=0, sticky_ovf=0 immediately; in_ready=1 after the first edge post-release.
- Single pass: push result=4'hA, op=3'b001, ovf=0 with out_ready=0 -> next cycle out_valid=1, out_result=4'hA, out_op=3'b001, out_zero=0; raise out_ready -> out_valid=0 after the edge.
- Fill and order: push 4'h1,4'h2,4'h3,4'h4 back-to-back with out_ready=0 -> count=4, in_ready=0; a fifth push of 4'h5 is ignored; drain -> outputs 1,2,3,4 in order, then count=0.
- Wrap and simultaneous: hold in_valid and out_ready high for 10 cycles with incrementing data and count=2 -> count stays 2, outputs in order across pointer wrap.
- Flags: push result=4'h0 with ovf=1 -> out_zero=1, out_ovf=1, sticky_ovf=1; later push ovf=1 on the same edge as sticky_clr=1 -> sticky_ovf stays 1; sticky_clr alone -> 0.
- With ALU_RESULT_FIFO_PARITY_EN: push 4'h7 with inj_par=1 -> out_par_err=1 while that entry is at the head; a clean push -> out_par_err=0.
